led_fade: RTL and testbench
===========================

# led_fade

Per-channel LED fade engine placed between an LED pattern source (the static LED logic or the reconfigurable LED partition) and the board LED pins. Each on/off request on `led_in` becomes a linear brightness ramp, rising on 0→1 and falling on 1→0, rendered by a shared free-running PWM counter. A `bypass` input passes the raw pattern straight through for debug.

## Interface
- `N_CH`, default 2: number of LED channels.
- `PWM_BITS`, default 8: PWM counter and brightness level width; MAX = 2^PWM_BITS−1.
- `STEP_DIV`, default 100000: clocks per brightness step; legal range ≥1.

- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `led_in` input N_CH: requested LED state per channel, synchronous to `clk`.
- `bypass` input 1: 1 = `led_out` follows `led_in` with no fading.
- `led_out` output N_CH: PWM-modulated LED drive, registered.
- `busy` output N_CH: per channel, 1 while a ramp is in progress (state RISE or FALL), registered.

## Operation
- Input stage: `led_q` ← `led_in` every clock.
- Prescaler: `pre_cnt` counts 0..STEP_DIV−1 and wraps to 0. `step_tick` = (`pre_cnt` == STEP_DIV−1). With STEP_DIV = 1, `step_tick` is high every cycle.
- PWM counter: `pwm_cnt`, PWM_BITS wide, increments every clock and wraps from MAX to 0. It is shared by all channels.
- Per-channel `level` (PWM_BITS wide) and a state machine with states OFF, RISE, ON, FALL:
  - OFF (`level` = 0): `led_q` = 1 → RISE.
  - RISE: on `step_tick`, `level`+1. Reaching MAX → ON. If `led_q` = 0 → FALL from the current level (immediate reversal, no jump).
  - ON (`level` = MAX): `led_q` = 0 → FALL.
  - FALL: on `step_tick`, `level`−1. Reaching 0 → OFF. If `led_q` = 1 → RISE from the current level.
- `level` saturates and never wraps. It never exceeds MAX and never goes below 0.
- When a state change and a `step_tick` land in the same cycle, the new direction applies on that tick. Example: OFF with `led_q` = 1 and `step_tick` = 1 gives `level` = 1, state RISE.
- PWM compare: `led_out[i]` ← (`level` == MAX) | (`level` > `pwm_cnt`). Duty is `level`/2^PWM_BITS. `level` = MAX gives a constant 1. `level` = 0 gives a constant 0.
- `busy[i]` ← (state == RISE) | (state == FALL).
- Bypass:
  - While `bypass` = 1, `led_out` ← `led_q` and `busy` ← 0.
  - `level` snaps to MAX if `led_q` = 1, otherwise 0. State snaps to ON or OFF to match.
  - On `bypass` falling, fading resumes from the snapped state with no glitch.
- `bypass` is sampled directly and is not synchronised. It is quasi-static.

## Timing
- Reset values, applied asynchronously: `led_q` = 0, `pre_cnt` = 0, `pwm_cnt` = 0, `level` = 0, state OFF, `led_out` = 0, `busy` = 0.
- First `step_tick` occurs in the STEP_DIV-th clock after `rst` deasserts.
- Request to state change: `led_in` edge → `led_q` +1 clock → state and `busy` update +1 more clock.
  - `busy` rises 2 clocks after the `led_in` edge.
  - `level` first moves on the first `step_tick` at or after the cycle in which `led_q` changes.
- Full ramp from 0 to MAX takes exactly MAX `step_tick`s = MAX·STEP_DIV clocks (±1 tick of alignment).
- `level` → `led_out` latency is 1 clock.
- Bypass path: `led_in` → `led_out` in 2 clocks.
- `rst` asserted mid-ramp clears everything immediately. After release the channel is in OFF, and `led_out` stays 0 until a new ramp starts.

## Test plan
Bench parameters: N_CH = 2, PWM_BITS = 4 (MAX = 15), STEP_DIV = 4.
- **Reset:** hold `rst`, drive `led_in` = 2'b11 → `led_out` = 0, `busy` = 0. Release → `busy` = 2'b11 two clocks later; `led_out[0]` is never high before the first tick.
- **Full rise:** `led_in[0]` 0→1 → `level` increments once per 4 clocks and reaches 15 after 60 clocks (±4). `busy[0]` then drops, and `led_out[0]` is constantly 1. At `level` = 8, measured duty is 8/16.
- **Mid-ramp reversal:** rise to `level` = 6, then drop `led_in[0]` → `level` goes 6→5→…→0 with no jump; state FALL, then OFF; `busy[0]` = 0 at 0.
- **Bypass:** during a rise at `level` = 9, set `bypass` = 1 → `led_out[0]` = 1 two clocks after `led_in` and `busy` = 0. Clear `bypass` with `led_in` = 1 → `led_out[0]` stays constantly 1 (`level` = 15).
- **Async reset mid-ramp:** assert `rst` at `level` = 7 between clock edges → `led_out` = 0 and `busy` = 0 before the next edge. After release, a channel with `led_in` = 1 ramps again from 0.
- **Independence and saturation:** channel 0 held on and channel 1 toggled every 20 clocks → channel 0 stays at 15 throughout. Channel 1's `level` never exceeds 15 and never goes below 0.

Source files
------------

// File: rtl/led_fade.sv
// led_fade: per-channel LED fade engine between an LED pattern source and the
// board LED pins. Each on/off request becomes a linear brightness ramp that is
// rendered by one shared free-running PWM counter.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   rst      asynchronous, active-high reset
//   led_in   [N_CH] requested LED state per channel (synchronous to clk)
//   bypass   1 = led_out follows led_in with no fading (quasi-static debug)
//   led_out  [N_CH] PWM-modulated LED drive, registered
//   busy     [N_CH] 1 while a channel is ramping (RISE or FALL), registered
module led_fade #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP_DIV = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] led_in,
    input  logic            bypass,
    output logic [N_CH-1:0] led_out,
    output logic [N_CH-1:0] busy
);

    localparam int unsigned PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
    localparam logic [PWM_BITS-1:0] LVL_MIN = '0;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    logic [N_CH-1:0]     led_q, led_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                step_tick_c;

    logic [PWM_BITS-1:0] level_q [N_CH];
    logic [PWM_BITS-1:0] level_d [N_CH];
    state_t              state_q [N_CH];
    state_t              state_d [N_CH];

    logic [N_CH-1:0]     led_out_q, led_out_d;
    logic [N_CH-1:0]     busy_q, busy_d;
    logic [N_CH-1:0]     rise_c, fall_c;

    assign led_out = led_out_q;
    assign busy    = busy_q;

    // Input stage, step prescaler and shared PWM counter.
    always_comb begin
        led_d       = led_in;
        step_tick_c = (pre_cnt_q == PRE_W'(STEP_DIV - 1));
        pre_cnt_d   = step_tick_c ? '0 : pre_cnt_q + PRE_W'(1);
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    end

    // Per-channel ramp state machine, PWM compare and bypass snapping.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            level_d[i]   = level_q[i];
            state_d[i]   = state_q[i];
            rise_c[i]    = 1'b0;
            fall_c[i]    = 1'b0;
            led_out_d[i] = 1'b0;
            busy_d[i]    = 1'b0;
        end

        for (int unsigned i = 0; i < N_CH; i++) begin
            if (bypass) begin
                // Keep level/state consistent with the raw pattern so fading
                // resumes glitch-free when bypass is released.
                level_d[i]   = led_q[i] ? LVL_MAX : LVL_MIN;
                state_d[i]   = led_q[i] ? ST_ON : ST_OFF;
                led_out_d[i] = led_q[i];
                busy_d[i]    = 1'b0;
            end else begin
                // Direction for this cycle; a reversal takes effect on the
                // same tick it coincides with.
                case (state_q[i])
                    ST_OFF:  rise_c[i] = led_q[i];
                    ST_RISE: begin
                        rise_c[i] = led_q[i];
                        fall_c[i] = ~led_q[i];
                    end
                    ST_ON:   fall_c[i] = ~led_q[i];
                    ST_FALL: begin
                        rise_c[i] = led_q[i];
                        fall_c[i] = ~led_q[i];
                    end
                    default: begin
                        rise_c[i] = 1'b0;
                        fall_c[i] = 1'b0;
                    end
                endcase

                if (rise_c[i]) begin
                    state_d[i] = ST_RISE;
                    if (step_tick_c && (level_q[i] != LVL_MAX)) begin
                        level_d[i] = level_q[i] + PWM_BITS'(1);
                    end
                    if (level_d[i] == LVL_MAX) begin
                        state_d[i] = ST_ON;
                    end
                end else if (fall_c[i]) begin
                    state_d[i] = ST_FALL;
                    if (step_tick_c && (level_q[i] != LVL_MIN)) begin
                        level_d[i] = level_q[i] - PWM_BITS'(1);
                    end
                    if (level_d[i] == LVL_MIN) begin
                        state_d[i] = ST_OFF;
                    end
                end

                // MAX is forced fully on; otherwise duty is level/2^PWM_BITS.
                led_out_d[i] = (level_q[i] == LVL_MAX) || (level_q[i] > pwm_cnt_q);
                busy_d[i]    = (state_d[i] == ST_RISE) || (state_d[i] == ST_FALL);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= '0;
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
            led_out_q <= '0;
            busy_q    <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                level_q[i] <= '0;
                state_q[i] <= ST_OFF;
            end
        end else begin
            led_q     <= led_d;
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_out_q <= led_out_d;
            busy_q    <= busy_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                level_q[i] <= level_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

endmodule

// File: tb/tb_led_fade.sv
// tb_led_fade: scoreboard bench for led_fade (N_CH=2, PWM_BITS=4, STEP_DIV=4).
// Stimulus pushes expected led_out/busy values tagged with the clock edge they
// belong to; a monitor samples on the falling edge and pops/compares.
// Edge k means the k-th rising edge after the latest reset release; the PWM
// counter then holds k mod 16 and a brightness step lands on every 4th edge.
module tb_led_fade;

    localparam int unsigned N_CH     = 2;
    localparam int unsigned PWM_BITS = 4;
    localparam int unsigned STEP_DIV = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] led_in;
    logic            bypass;
    logic [N_CH-1:0] led_out;
    logic [N_CH-1:0] busy;

    led_fade #(
        .N_CH     (N_CH),
        .PWM_BITS (PWM_BITS),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .led_in  (led_in),
        .bypass  (bypass),
        .led_out (led_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    int base = 0;
    int n_tests = 0;
    int n_fail = 0;

    int         when_q [$];
    logic [1:0] eout_q [$];
    logic [1:0] ebusy_q[$];
    logic [1:0] mout_q [$];
    logic [1:0] mbusy_q[$];
    string      name_q [$];

    task automatic push_abs(input int w, input logic [1:0] eo, input logic [1:0] eb,
                            input logic [1:0] mo, input logic [1:0] mb, input string nm);
        when_q.push_back(w);
        eout_q.push_back(eo);
        ebusy_q.push_back(eb);
        mout_q.push_back(mo);
        mbusy_q.push_back(mb);
        name_q.push_back(nm);
    endtask

    task automatic chk(input int k, input logic [1:0] eo, input logic [1:0] eb, input string nm);
        push_abs(base + k, eo, eb, 2'b11, 2'b11, nm);
    endtask

    task automatic chk_range(input int k0, input int k1, input logic [1:0] eo,
                             input logic [1:0] eb, input logic [1:0] m, input string nm);
        for (int k = k0; k <= k1; k++) push_abs(base + k, eo, eb, m, m, nm);
    endtask

    task automatic wait_edge(input int k);
        while (pcyc < base + k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain();
        while (when_q.size() > 0) @(posedge clk);
        #2;
    endtask

    // Assert reset with the given pattern, check the cleared outputs, release.
    task automatic start_reset(input logic [1:0] li);
        @(posedge clk);
        #2;
        rst    = 1'b1;
        bypass = 1'b0;
        led_in = li;
        push_abs(pcyc, 2'b00, 2'b00, 2'b11, 2'b11, "rst_hold");
        repeat (3) @(posedge clk);
        #2;
        rst  = 1'b0;
        base = pcyc;
    endtask

    // Monitor: compare every entry whose edge has been reached.
    always @(negedge clk) begin
        while (when_q.size() > 0 && when_q[0] <= pcyc) begin
            n_tests = n_tests + 1;
            if (when_q[0] < pcyc) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: sample for cycle %0d missed (now %0d)", name_q[0], when_q[0], pcyc);
            end else if ((((led_out ^ eout_q[0]) & mout_q[0]) != 2'b00) ||
                         (((busy ^ ebusy_q[0]) & mbusy_q[0]) != 2'b00)) begin
                n_fail = n_fail + 1;
                $display("FAIL %s @cycle %0d: led_out=%b busy=%b, required led_out=%b busy=%b (checked bits %b/%b)",
                         name_q[0], pcyc - base, led_out, busy, eout_q[0], ebusy_q[0], mout_q[0], mbusy_q[0]);
            end
            void'(when_q.pop_front());
            void'(eout_q.pop_front());
            void'(ebusy_q.pop_front());
            void'(mout_q.pop_front());
            void'(mbusy_q.pop_front());
            void'(name_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst    = 1'b1;
        led_in = 2'b00;
        bypass = 1'b0;

        // Reset with both requests high, then a full rise on both channels.
        start_reset(2'b11);
        chk(1,  2'b00, 2'b00, "busy_before_state");
        chk(2,  2'b00, 2'b11, "busy_two_clocks");
        chk(4,  2'b00, 2'b11, "dark_first_tick");
        chk(16, 2'b00, 2'b11, "dark_level3");
        chk(17, 2'b11, 2'b11, "level4_pwm0");
        chk(21, 2'b11, 2'b11, "level5_pwm4");
        chk(22, 2'b00, 2'b11, "level5_pwm5");
        chk(33, 2'b11, 2'b11, "level8_pwm0");
        chk(42, 2'b11, 2'b11, "level10_pwm9");
        chk(43, 2'b00, 2'b11, "level10_pwm10");
        chk(59, 2'b11, 2'b11, "level14_busy");
        chk(60, 2'b11, 2'b00, "reach_max");
        chk_range(61, 92, 2'b11, 2'b00, 2'b11, "max_steady");
        drain();

        // Mid-ramp reversal at level 6 on channel 0.
        start_reset(2'b01);
        chk(2,  2'b00, 2'b01, "rev_busy");
        chk(21, 2'b01, 2'b01, "rev_level5_pwm4");
        chk(22, 2'b00, 2'b01, "rev_level5_pwm5");
        chk(24, 2'b00, 2'b01, "rev_level5_pwm7");
        chk(25, 2'b00, 2'b01, "rev_level6");
        chk(26, 2'b00, 2'b01, "rev_fall");
        chk(33, 2'b01, 2'b01, "fall_level4_pwm0");
        chk(36, 2'b01, 2'b01, "fall_level4_pwm3");
        chk(37, 2'b00, 2'b01, "fall_level3_pwm4");
        chk(41, 2'b00, 2'b01, "fall_level2_pwm8");
        chk(47, 2'b00, 2'b01, "fall_level1_busy");
        chk(48, 2'b00, 2'b00, "fall_off");
        chk_range(49, 80, 2'b00, 2'b00, 2'b11, "off_steady");
        wait_edge(24);
        led_in = 2'b00;
        drain();

        // Bypass entered at level 9, pattern toggled, bypass released while on.
        start_reset(2'b01);
        chk(2,  2'b00, 2'b01, "byp_busy");
        chk(37, 2'b01, 2'b01, "byp_level9_pwm4");
        chk(38, 2'b01, 2'b00, "byp_enter");
        chk(40, 2'b01, 2'b00, "byp_hold");
        chk(41, 2'b01, 2'b00, "byp_lat1");
        chk(42, 2'b00, 2'b00, "byp_off");
        chk(44, 2'b00, 2'b00, "byp_off_hold");
        chk(45, 2'b00, 2'b00, "byp_on_lat1");
        chk(46, 2'b01, 2'b00, "byp_on");
        chk(50, 2'b01, 2'b00, "byp_on_hold");
        chk_range(51, 82, 2'b01, 2'b00, 2'b11, "byp_release");
        wait_edge(37);
        bypass = 1'b1;
        wait_edge(40);
        led_in = 2'b00;
        wait_edge(44);
        led_in = 2'b01;
        wait_edge(50);
        bypass = 1'b0;
        drain();

        // Asynchronous reset between edges at level 7, then a fresh ramp.
        start_reset(2'b01);
        chk(2,  2'b00, 2'b01, "pre_busy");
        chk(17, 2'b01, 2'b01, "pre_lit");
        chk(28, 2'b00, 2'b01, "pre_level7_busy");
        chk(29, 2'b00, 2'b00, "async_clear");
        wait_edge(29);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst  = 1'b0;
        base = pcyc;
        chk(1,  2'b00, 2'b00, "post_rst_idle");
        chk(2,  2'b00, 2'b01, "post_rst_busy");
        chk(16, 2'b00, 2'b01, "post_rst_dark");
        chk(17, 2'b01, 2'b01, "post_rst_ramp");
        drain();

        // Channel 0 held on while channel 1 toggles, then floor and ceiling.
        start_reset(2'b01);
        chk(2,  2'b00, 2'b01, "ind_busy");
        chk(60, 2'b01, 2'b00, "ind_ch0_max");
        wait_edge(64);
        k = 64;
        for (int t = 0; t < 8; t++) begin
            led_in[1] = ((t % 2) == 0);
            chk_range(k + 1, k + 20, 2'b01, 2'b00, 2'b01, "ind_ch0_hold");
            wait_edge(k + 20);
            k = k + 20;
        end
        chk_range(k + 1, k + 80, 2'b01, 2'b00, 2'b01, "ind_ch0_hold");
        chk_range(k + 81, k + 112, 2'b01, 2'b00, 2'b11, "ch1_floor");
        wait_edge(k + 112);
        k = k + 112;
        led_in = 2'b11;
        chk_range(k + 1, k + 100, 2'b01, 2'b00, 2'b01, "ind_ch0_hold");
        chk_range(k + 101, k + 132, 2'b11, 2'b00, 2'b11, "ch1_ceiling");
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
